// File: rtl/mem_arb_pkg.sv
// Shared types for the two-requester memory arbiter:
// FSM state encoding and requester ids.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  function automatic logic [7:0] id_char(input logic id);
    return id ? 8'h42 : 8'h41;
  endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous word store with a registered read.
// Accesses outside 0..memory_size-1 are ignored.
module mem_array #(
  parameter int addr_size   = 10,
  parameter int word_size   = 8,
  parameter int memory_size = 1024
) (
  input  logic                 clk,
  input  logic                 cs,
  input  logic                 wr,
  input  logic [addr_size-1:0] addr,
  input  logic [word_size-1:0] din,
  output logic [word_size-1:0] dout
);

  localparam logic [addr_size:0] LIMIT =
    (addr_size + 1)'(memory_size);

  logic [word_size-1:0] mem [memory_size];
  logic                 ok;

  assign ok = {1'b0, addr} < LIMIT;

  always_ff @(posedge clk) begin
    if (cs && ok) begin
      if (wr) begin
        mem[addr] <= din;
      end
      dout <= mem[addr];
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of a single-port memory.
// MEM_ARB_FIXED_PRIO_EN selects fixed A-first priority instead of round-robin.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int addr_size   = 10,
  parameter int word_size   = 8,
  parameter int memory_size = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 a_req,
  input  logic                 b_req,
  input  logic                 a_wr,
  input  logic                 b_wr,
  input  logic [addr_size-1:0] a_addr,
  input  logic [addr_size-1:0] b_addr,
  input  logic [word_size-1:0] a_wdata,
  input  logic [word_size-1:0] b_wdata,
  output logic                 a_ack,
  output logic                 b_ack,
  output logic [word_size-1:0] a_rdata,
  output logic [word_size-1:0] b_rdata,
  output logic                 err,
  output logic                 busy
);

  localparam logic [addr_size:0] LIMIT =
    (addr_size + 1)'(memory_size);

  state_t               state;
  state_t               state_nxt;
  logic                 sel;
  logic                 grant;
  logic                 gnt;
  logic                 wr_q;
  logic [addr_size-1:0] addr_q;
  logic [word_size-1:0] wdata_q;
  logic                 in_range;
  logic                 cs;
  logic                 mem_wr;
  logic [word_size-1:0] dout;
  logic [word_size-1:0] rd;

  assign grant = (state == IDLE) && (a_req || b_req);

`ifdef MEM_ARB_FIXED_PRIO_EN
  assign sel = a_req ? REQ_A : REQ_B;
`else
  logic last;

  // Contention goes to whoever was not served last.
  assign sel = (a_req && b_req) ? ~last
             : (a_req ? REQ_A : REQ_B);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last <= REQ_B;
    end else if (grant) begin
      last <= sel;
    end
  end
`endif

  assign in_range = {1'b0, addr_q} < LIMIT;
  assign busy     = (state != IDLE);
  assign rd       = (in_range && !wr_q) ? dout : '0;

  always_comb begin
    state_nxt = state;
    cs        = 1'b0;
    mem_wr    = 1'b0;
    unique case (state)
      IDLE: begin
        if (a_req || b_req) begin
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        cs        = 1'b1;
        mem_wr    = wr_q && in_range;
        state_nxt = RESP;
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Request fields are captured once at grant and held for the access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt     <= REQ_A;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (grant) begin
      gnt     <= sel;
      wr_q    <= sel ? b_wr : a_wr;
      addr_q  <= sel ? b_addr : a_addr;
      wdata_q <= sel ? b_wdata : a_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_ack   <= 1'b0;
      b_ack   <= 1'b0;
      a_rdata <= '0;
      b_rdata <= '0;
      err     <= 1'b0;
    end else begin
      a_ack   <= 1'b0;
      b_ack   <= 1'b0;
      a_rdata <= '0;
      b_rdata <= '0;
      err     <= 1'b0;
      if (state == RESP) begin
        err <= !in_range;
        if (gnt == REQ_B) begin
          b_ack   <= 1'b1;
          b_rdata <= rd;
        end else begin
          a_ack   <= 1'b1;
          a_rdata <= rd;
        end
      end
    end
  end

  mem_array #(
    .addr_size  (addr_size),
    .word_size  (word_size),
    .memory_size(memory_size)
  ) u_mem (
    .clk (clk),
    .cs  (cs),
    .wr  (mem_wr),
    .addr(addr_q),
    .din (wdata_q),
    .dout(dout)
  );

endmodule
